// File: rtl/id_stage_if.sv
// Handshake bundle between fetch, the RV32I decode stage and execute.
// The master side drives the fetch and execute inputs; the slave side is the decode stage.
interface id_stage_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [ADDR_W-1:0] in_pc;
    logic              flush;
    logic [REG_AW-1:0] rf_rd1_addr;
    logic [REG_AW-1:0] rf_rd2_addr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [REG_AW-1:0] out_rd;
    logic [XLEN-1:0]   out_imm;
    logic              out_mem_rd;
    logic              out_mem_wr;
    logic [11:0]       out_csr_addr;
    logic [XLEN-1:0]   out_csr_zimm;
    logic              out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, rf_rd1_addr, rf_rd2_addr, out_valid, out_inst, out_pc,
               out_rs1, out_rs2, out_rd, out_imm, out_mem_rd, out_mem_wr,
               out_csr_addr, out_csr_zimm, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, rf_rd1_addr, rf_rd2_addr, out_valid, out_inst, out_pc,
               out_rs1, out_rs2, out_rd, out_imm, out_mem_rd, out_mem_wr,
               out_csr_addr, out_csr_zimm, out_illegal
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage: field/immediate extraction, load-use bubble,
// flush, separate load/store flags, illegal detection and optional CSR decode.
module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5,
    parameter int CSR_EN = 1
) (
    input logic        clk,
    input logic        rst,
    id_stage_if.slave  bus
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm;
        logic              mem_rd;
        logic              mem_wr;
        logic [11:0]       csr_addr;
        logic [XLEN-1:0]   zimm;
        logic              illegal;
    } dec_t;

    logic [31:0]       inst_s;
    logic [6:0]        opc_s;
    logic [2:0]        f3_s;
    logic [6:0]        f7_s;
    logic [REG_AW-1:0] rs1_f_s, rs2_f_s, rd_f_s;
    logic [XLEN-1:0]   imm_i_s, imm_s_s, imm_b_s, imm_j_s, imm_u_s, shamt_s;
    dec_t              dec_s, fin_s;
    logic              legal_s, hazard_s, in_ready_s, accept_s;

    dec_t              out_r;
    logic              out_valid_r;
    logic [31:0]       out_inst_r;
    logic [ADDR_W-1:0] out_pc_r;

    assign inst_s  = bus.in_inst;
    assign opc_s   = inst_s[6:0];
    assign f3_s    = inst_s[14:12];
    assign f7_s    = inst_s[31:25];
    assign rs1_f_s = REG_AW'(inst_s[19:15]);
    assign rs2_f_s = REG_AW'(inst_s[24:20]);
    assign rd_f_s  = REG_AW'(inst_s[11:7]);

    assign imm_i_s = {{(XLEN-12){inst_s[31]}}, inst_s[31:20]};
    assign imm_s_s = {{(XLEN-12){inst_s[31]}}, inst_s[31:25], inst_s[11:7]};
    assign imm_b_s = {{(XLEN-13){inst_s[31]}}, inst_s[31], inst_s[7], inst_s[30:25], inst_s[11:8], 1'b0};
    assign imm_j_s = {{(XLEN-21){inst_s[31]}}, inst_s[31], inst_s[19:12], inst_s[20], inst_s[30:21], 1'b0};
    assign imm_u_s = XLEN'({inst_s[31:12], 12'h000});
    assign shamt_s = {{(XLEN-5){1'b0}}, inst_s[24:20]};

    // Raw field decode; only sources the opcode actually reads are populated
    always_comb begin
        dec_s   = '0;
        legal_s = 1'b1;
        case (opc_s)
            OPC_OP_IMM: begin
                dec_s.rs1 = rs1_f_s;
                dec_s.rd  = rd_f_s;
                if ((f3_s == 3'b001) || (f3_s == 3'b101)) begin
                    dec_s.imm = shamt_s;
                    legal_s   = (f7_s == 7'b0000000) || ((f3_s == 3'b101) && (f7_s == 7'b0100000));
                end else begin
                    dec_s.imm = imm_i_s;
                end
            end
            OPC_OP: begin
                dec_s.rs1 = rs1_f_s;
                dec_s.rs2 = rs2_f_s;
                dec_s.rd  = rd_f_s;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_s.rd  = rd_f_s;
                dec_s.imm = imm_u_s;
            end
            OPC_JAL: begin
                dec_s.rd  = rd_f_s;
                dec_s.imm = imm_j_s;
            end
            OPC_JALR: begin
                dec_s.rs1 = rs1_f_s;
                dec_s.rd  = rd_f_s;
                dec_s.imm = imm_i_s;
            end
            OPC_BRANCH: begin
                dec_s.rs1 = rs1_f_s;
                dec_s.rs2 = rs2_f_s;
                dec_s.imm = imm_b_s;
            end
            OPC_STORE: begin
                dec_s.rs1    = rs1_f_s;
                dec_s.rs2    = rs2_f_s;
                dec_s.imm    = imm_s_s;
                dec_s.mem_wr = 1'b1;
            end
            OPC_LOAD: begin
                dec_s.rs1    = rs1_f_s;
                dec_s.rd     = rd_f_s;
                dec_s.imm    = imm_i_s;
                dec_s.mem_rd = 1'b1;
            end
            OPC_SYSTEM: begin
                if (CSR_EN != 0) begin
                    case (f3_s)
                        3'b001, 3'b010, 3'b011: begin
                            dec_s.rs1      = rs1_f_s;
                            dec_s.rd       = rd_f_s;
                            dec_s.csr_addr = inst_s[31:20];
                        end
                        3'b101, 3'b110, 3'b111: begin
                            dec_s.rd       = rd_f_s;
                            dec_s.csr_addr = inst_s[31:20];
                            dec_s.zimm     = {{(XLEN-5){1'b0}}, inst_s[19:15]};
                        end
                        default: legal_s = 1'b0;
                    endcase
                end else begin
                    legal_s = 1'b0;
                end
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Illegal encodings travel down the pipe with every decoded field cleared
    always_comb begin
        fin_s = dec_s;
        if (!legal_s) begin
            fin_s         = '0;
            fin_s.illegal = 1'b1;
        end else begin
            fin_s.illegal = 1'b0;
        end
    end

    // Zero sources are never populated against a nonzero out_rd, so they cannot stall
    assign hazard_s   = out_valid_r & out_r.mem_rd & (out_r.rd != '0) &
                        ((fin_s.rs1 == out_r.rd) | (fin_s.rs2 == out_r.rd));
    assign in_ready_s = ~rst & ~bus.flush & ~hazard_s & (~out_valid_r | bus.out_ready);
    assign accept_s   = bus.in_valid & in_ready_s;

    // ID/EX register: reset, then flush, then accept, then drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_inst_r  <= '0;
            out_pc_r    <= '0;
            out_r       <= '0;
        end else if (bus.flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_inst_r  <= bus.in_inst;
            out_pc_r    <= bus.in_pc;
            out_r       <= fin_s;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.rf_rd1_addr  = fin_s.rs1;
    assign bus.rf_rd2_addr  = fin_s.rs2;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_inst     = out_inst_r;
    assign bus.out_pc       = out_pc_r;
    assign bus.out_rs1      = out_r.rs1;
    assign bus.out_rs2      = out_r.rs2;
    assign bus.out_rd       = out_r.rd;
    assign bus.out_imm      = out_r.imm;
    assign bus.out_mem_rd   = out_r.mem_rd;
    assign bus.out_mem_wr   = out_r.mem_wr;
    assign bus.out_csr_addr = out_r.csr_addr;
    assign bus.out_csr_zimm = out_r.zimm;
    assign bus.out_illegal  = out_r.illegal;
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised, registered RV32I instruction decode stage with valid/ready handshakes on both sides. It sits between the fetch stage and the execute stage and absorbs the ID/EX pipeline register. Beyond field extraction, it detects load-use hazards and inserts a bubble, supports pipeline flush, separates load and store memory flags, and flags illegal instructions. CSR decode is enabled per build.

Parameters:
XLEN, 32, data and immediate width (32 only in this generation; sign-extension targets XLEN)
ADDR_W, 32, instruction address width
REG_AW, 5, register-file address width
CSR_EN, 1, 1 = decode SYSTEM/CSR opcodes; 0 = treat opcode 1110011 as illegal

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_inst  in  32  instruction word
in_pc  in  ADDR_W  instruction address
flush  in  1  kill the held and incoming instruction (branch/trap redirect)
rf_rd1_addr  out  REG_AW  combinational rs1 address to the register file, decoded from in_inst
rf_rd2_addr  out  REG_AW  combinational rs2 address to the register file, decoded from in_inst
out_valid  out  1  registered decoded instruction is valid
out_ready  in  1  execute stage consumes the output
out_inst  out  32  registered instruction word
out_pc  out  ADDR_W  registered PC
out_rs1, out_rs2, out_rd  out  REG_AW each  registered register addresses
out_imm  out  XLEN  registered immediate
out_mem_rd  out  1  instruction is a load
out_mem_wr  out  1  instruction is a store
out_csr_addr  out  12  CSR address
out_csr_zimm  out  XLEN  zero-extended 5-bit CSR immediate
out_illegal  out  1  illegal or unsupported encoding

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0 and every registered output is 0. in_ready is combinationally 0 while rst=1.
- Opcodes:
  - OP-IMM 0010011: rs1, rd, I-imm. For SLLI/SRLI/SRAI, imm = zero-extended shamt [24:20]. Illegal if funct7 is not 0000000 (or 0100000 for SRAI).
  - OP 0110011: rs1, rs2, rd, imm=0.
  - LUI 0110111 / AUIPC 0010111: rd, imm = {inst[31:12], 12'b0}.
  - JAL 1101111: rd, J-imm. JALR 1100111: rs1, rd, I-imm.
  - BRANCH 1100011: rs1, rs2, B-imm, rd=0.
  - STORE 0100011: rs1, rs2, S-imm, rd=0, mem_wr=1.
  - LOAD 0000011: rs1, rd, I-imm, mem_rd=1.
  - SYSTEM 1110011 (CSR_EN=1):
    - funct3 001/010/011: rs1, rd, csr_addr = inst[31:20].
    - funct3 101/110/111: rs1=0, zimm = inst[19:15].
    - funct3 000/100: illegal.
  - Any other opcode: illegal.
- Illegal instructions: all register, imm and mem fields are 0, out_illegal=1, and the instruction still flows as valid.
- All immediates are sign-extended from inst[31] except shamt and zimm. Unused source fields are 0, and a zero source never causes a hazard.
- Handshake:
  - accept = in_valid & in_ready. Output register loads on accept.
  - in_ready = !rst & !flush & !hazard & (!out_valid | out_ready).
  - If out_valid & out_ready & !accept, then out_valid←0.
  - If out_valid & !out_ready, all outputs hold stable.
- Hazard (combinational) = out_valid & out_mem_rd & out_rd≠0 & (src1 of in_inst == out_rd or src2 of in_inst == out_rd), considering only sources the incoming instruction uses. While hazard: in_ready=0. When the held load fires, a bubble (out_valid=0) follows. The dependent instruction is accepted the next cycle, so there is exactly one bubble.
- Flush: at the next edge out_valid←0. The incoming instruction is not accepted (in_ready=0). Flush has priority over hazard and accept; rst has priority over flush.
- Latency: 1 cycle from accept to out_valid. Throughput is 1 instruction per cycle without hazards or backpressure.
- rf_rd*_addr follow in_inst combinationally regardless of in_valid.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1 → in_ready=0, out_valid=0, all outputs 0.
2. addi x1,x2,-1 (0xFFF10093), out_ready=1 → next cycle out_valid=1, out_rd=1, out_rs1=2, out_rs2=0, out_imm=0xFFFFFFFF, out_illegal=0.
3. lw x5,0(x1) (0x0000A283) then add x6,x5,x5 (0x00528333) back-to-back, out_ready=1 → lw out at T+1 with mem_rd=1; T+2 out_valid=0 (bubble); add out at T+3 with rs1=rs2=5, rd=6.
4. Backpressure: out_valid=1 and out_ready=0 for 3 cycles → outputs bit-identical each cycle, in_ready=0. out_ready=1 → next instruction appears the following cycle.
5. flush asserted with in_valid=1 and out_valid=1 → in_ready=0 that cycle, out_valid=0 next cycle, dropped instruction never appears.
6. csrrw x0,0x305,x5 (0x30529073): CSR_EN=1 → out_csr_addr=0x305, out_rs1=5, out_illegal=0; CSR_EN=0 → out_illegal=1 with all fields 0. Opcode 0x7F → out_illegal=1.
